mips_multicycle_ctrl: RTL

- Control unit that sequences the multicycle MIPS datapath: one instruction spread over 3–5 clocks, sharing one memory and one ALU.
- Moore FSM (main decoder) plus combinational ALU decoder.
- Drives all datapath enables and muxes from `op`/`funct`/`zero`.
- Sits beside the multicycle datapath inside `top`; the datapath owns PC, IR, register file and memory.

---
 rtl/mips_ctrl_pkg.sv | 18 +
 rtl/aludec.sv | 16 +
 rtl/mips_multicycle_ctrl.sv | 107 ++++++++++
 3 files changed

// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg: opcode/funct/alucontrol codes, aluop and state encodings.
// Defining MC_BNE_EN adds the BNE state.
package mips_ctrl_pkg;
  localparam logic [5:0] OP_RTYPE = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011,
                         OP_BEQ = 6'b000100, OP_BNE = 6'b000101, OP_ADDI = 6'b001000,
                         OP_J = 6'b000010;
  localparam logic [5:0] F_ADD = 6'b100000, F_SUB = 6'b100010, F_AND = 6'b100100,
                         F_OR = 6'b100101, F_SLT = 6'b101010;
  localparam logic [2:0] AC_ADD = 3'b010, AC_SUB = 3'b110, AC_AND = 3'b000,
                         AC_OR = 3'b001, AC_SLT = 3'b111;
  typedef enum logic [1:0] {ALUOP_ADD = 2'b00, ALUOP_SUB = 2'b01, ALUOP_FUNCT = 2'b10} aluop_t;
  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTE, ALUWB, BRANCH, ADDIEXEC, ADDIWB, JUMP
`ifdef MC_BNE_EN
    , BNE
`endif
  } state_t;
endpackage

// File: rtl/aludec.sv
// aludec: aluop + funct -> alucontrol; unknown funct falls back to add.
module aludec
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] funct,
  input  logic [1:0] aluop,
  output logic [2:0] alucontrol
);
  always_comb
    alucontrol = aluop == ALUOP_ADD ? AC_ADD :
                 aluop == ALUOP_SUB ? AC_SUB :
                 funct == F_SUB ? AC_SUB :
                 funct == F_AND ? AC_AND :
                 funct == F_OR  ? AC_OR  :
                 funct == F_SLT ? AC_SLT : AC_ADD;
endmodule

// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl: Moore main decoder FSM for the multicycle MIPS datapath plus aludec.
// Optional MC_BNE_EN adds a BNE state with inverted branch condition.
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       iord,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [2:0] alucontrol,
  output logic       pcen
);
  logic [STATE_W-1:0] state;
  state_t nxt;
  aluop_t aluop;
  logic mw, rw, iw, pcwrite, branch, bn;
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= FETCH;
    else state <= nxt;
  always_comb begin
    nxt = FETCH;
    aluop = ALUOP_ADD;
    {iord, mw, iw, regdst, memtoreg, rw, alusrca, pcwrite, branch, bn} = '0;
    alusrcb = 2'b00;
    pcsrc = 2'b00;
    case (state)
      FETCH: begin
        iw = 1'b1;
        pcwrite = 1'b1;
        alusrcb = 2'b01;
        nxt = DECODE;
      end
      DECODE: begin
        alusrcb = 2'b11;
        nxt = (op == OP_LW || op == OP_SW) ? MEMADR :
              op == OP_RTYPE ? EXECUTE :
              op == OP_BEQ ? BRANCH :
              op == OP_ADDI ? ADDIEXEC :
              op == OP_J ? JUMP :
`ifdef MC_BNE_EN
              op == OP_BNE ? BNE :
`endif
              FETCH;
      end
      MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        nxt = op == OP_LW ? MEMRD : MEMWR;
      end
      MEMRD: begin
        iord = 1'b1;
        nxt = MEMWB;
      end
      MEMWB: {memtoreg, rw} = 2'b11;
      MEMWR: {iord, mw} = 2'b11;
      EXECUTE: begin
        alusrca = 1'b1;
        aluop = ALUOP_FUNCT;
        nxt = ALUWB;
      end
      ALUWB: {regdst, rw} = 2'b11;
      BRANCH: begin
        alusrca = 1'b1;
        aluop = ALUOP_SUB;
        pcsrc = 2'b01;
        branch = 1'b1;
      end
`ifdef MC_BNE_EN
      BNE: begin
        alusrca = 1'b1;
        aluop = ALUOP_SUB;
        pcsrc = 2'b01;
        bn = 1'b1;
      end
`endif
      ADDIEXEC: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        nxt = ADDIWB;
      end
      ADDIWB: rw = 1'b1;
      JUMP: begin
        pcsrc = 2'b10;
        pcwrite = 1'b1;
      end
      default: alusrcb = 2'b01;
    endcase
  end
  // reset masks every write enable so a mid-instruction reset never commits state
  assign memwrite = mw & ~reset;
  assign regwrite = rw & ~reset;
  assign irwrite = iw & ~reset;
  assign pcen = ~reset & (pcwrite | (branch & zero) | (bn & ~zero));
  aludec u_aludec (.funct(funct), .aluop(aluop), .alucontrol(alucontrol));
endmodule
